// File: rtl/list_cmd_arbiter.sv
// Round-robin arbiter sharing the lists_manager command port between NREQ requesters.
// Optional TICK_GUARD_EN: blocks grants at and right after an RTOS tick edge.
module list_cmd_arbiter #(
    parameter int unsigned NREQ        = 3,
    parameter int unsigned BUSY_CYCLES = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [3*NREQ-1:0]    req_op,
    input  logic [8*NREQ-1:0]    req_id,
    input  logic [32*NREQ-1:0]   req_tcb,
    input  logic [6*NREQ-1:0]    req_pri,
    input  logic [32*NREQ-1:0]   req_delay,
    input  logic                 tick_in,
    output logic [NREQ-1:0]      req_ready,
    output logic                 insertnew_cmd,
    output logic                 insert_cmd,
    output logic                 suspend_cmd,
    output logic                 delete_cmd,
    output logic                 ins_dlylist_out,
    output logic [7:0]           id_task_out,
    output logic [31:0]          tcb_task_out,
    output logic [5:0]           pri_task_out,
    output logic [31:0]          valuedelay_out,
    output logic                 busy_out,
    output logic [2:0]           grant_idx_out,
    output logic                 err_out
);

    localparam int unsigned OPW  = 3;
    localparam int unsigned IDW  = 8;
    localparam int unsigned TCBW = 32;
    localparam int unsigned PRIW = 6;
    localparam int unsigned DLYW = 32;
    localparam int unsigned GW   = 3;
    localparam int unsigned CMDW = 5;
    localparam int unsigned IW   = $clog2(NREQ);
    localparam int unsigned CW   = $clog2(BUSY_CYCLES + 1);

    localparam logic [OPW-1:0] OP_INSERTNEW = 3'd1;
    localparam logic [OPW-1:0] OP_INSERT    = 3'd2;
    localparam logic [OPW-1:0] OP_SUSPEND   = 3'd3;
    localparam logic [OPW-1:0] OP_DELETE    = 3'd4;
    localparam logic [OPW-1:0] OP_INS_DLY   = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [GW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]     ready_q, ready_d;
    logic [CMDW-1:0]     cmd_q, cmd_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic [GW-1:0]       gidx_q, gidx_d;
    logic [IDW-1:0]      id_q, id_d;
    logic [TCBW-1:0]     tcb_q, tcb_d;
    logic [PRIW-1:0]     pri_q, pri_d;
    logic [DLYW-1:0]     dly_q, dly_d;

    logic [OPW-1:0]      op_arr  [NREQ];
    logic [IDW-1:0]      id_arr  [NREQ];
    logic [TCBW-1:0]     tcb_arr [NREQ];
    logic [PRIW-1:0]     pri_arr [NREQ];
    logic [DLYW-1:0]     dly_arr [NREQ];

    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic [IW-1:0]       cand;
    logic                guard_c;

    // Unpack the flat requester buses into per-requester views.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign op_arr[g]  = req_op[OPW*g +: OPW];
        assign id_arr[g]  = req_id[IDW*g +: IDW];
        assign tcb_arr[g] = req_tcb[TCBW*g +: TCBW];
        assign pri_arr[g] = req_pri[PRIW*g +: PRIW];
        assign dly_arr[g] = req_delay[DLYW*g +: DLYW];
    end

    // One-hot command vector: {insertnew, insert, suspend, delete, ins_dly}; zero for invalid opcodes.
    function automatic logic [CMDW-1:0] op_decode(input logic [OPW-1:0] op);
        logic [CMDW-1:0] cmd;
        cmd = '0;
        case (op)
            OP_INSERTNEW: cmd = 5'b10000;
            OP_INSERT:    cmd = 5'b01000;
            OP_SUSPEND:   cmd = 5'b00100;
            OP_DELETE:    cmd = 5'b00010;
            OP_INS_DLY:   cmd = 5'b00001;
            default:      cmd = '0;
        endcase
        return cmd;
    endfunction

`ifdef TICK_GUARD_EN
    logic tick_q;

    // Remember the previous tick so the edge after a tick is also blocked.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_in;
        end
    end

    assign guard_c = tick_in | tick_q;
`else
    logic unused_tick;
    assign unused_tick = tick_in;
    assign guard_c     = 1'b0;
`endif

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr_q) + i) % NREQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            ready_q <= '0;
            cmd_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            gidx_q  <= '0;
            id_q    <= '0;
            tcb_q   <= '0;
            pri_q   <= '0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            gidx_q  <= gidx_d;
            id_q    <= id_d;
            tcb_q   <= tcb_d;
            pri_q   <= pri_d;
            dly_q   <= dly_d;
        end
    end

    // Next state; pulse outputs are computed one edge ahead so they land in ISSUE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ready_d = '0;
        cmd_d   = '0;
        err_d   = 1'b0;
        busy_d  = busy_q;
        gidx_d  = gidx_q;
        id_d    = id_q;
        tcb_d   = tcb_q;
        pri_d   = pri_q;
        dly_d   = dly_q;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (pick_found && !guard_c) begin
                    state_d           = S_ISSUE;
                    ptr_d             = GW'((32'(pick_idx) + 1) % NREQ);
                    gidx_d            = GW'(pick_idx);
                    id_d              = id_arr[pick_idx];
                    tcb_d             = tcb_arr[pick_idx];
                    pri_d             = pri_arr[pick_idx];
                    dly_d             = dly_arr[pick_idx];
                    ready_d[pick_idx] = 1'b1;
                    cmd_d             = op_decode(op_arr[pick_idx]);
                    err_d             = (op_decode(op_arr[pick_idx]) == '0);
                    busy_d            = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cmd_q != '0) begin
                    state_d = S_WAIT;
                    cnt_d   = CW'(BUSY_CYCLES);
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign req_ready       = ready_q;
    assign insertnew_cmd   = cmd_q[4];
    assign insert_cmd      = cmd_q[3];
    assign suspend_cmd     = cmd_q[2];
    assign delete_cmd      = cmd_q[1];
    assign ins_dlylist_out = cmd_q[0];
    assign err_out         = err_q;
    assign busy_out        = busy_q;
    assign grant_idx_out   = gidx_q;
    assign id_task_out     = id_q;
    assign tcb_task_out    = tcb_q;
    assign pri_task_out    = pri_q;
    assign valuedelay_out  = dly_q;

endmodule

// File: doc/list_cmd_arbiter.md
Name: list_cmd_arbiter

Overview:
- Shares the single command port of lists_manager between NREQ requesters: the AXI/CPU service path, the scheduler, and the delay-list expiry logic.
- Selects requesters round-robin and issues exactly one single-cycle command pulse to lists_manager.
- Holds the command operands stable through a fixed busy window so lists_manager can finish its list walk before the next command.
- Sits between the requesters and lists_manager in the RTOS list-manager IP.

Parameters:
NREQ, 3, number of requesters; legal range 2..8
BUSY_CYCLES, 4, cycles the port stays reserved after a command pulse; minimum 1

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester request; held until the matching req_ready
req_op  in  3*NREQ  per-requester opcode, slice k = [3k+2:3k]
req_id  in  8*NREQ  task id
req_tcb  in  32*NREQ  TCB address
req_pri  in  6*NREQ  priority
req_delay  in  32*NREQ  delay value
tick_in  in  1  RTOS tick strobe
req_ready  out  NREQ  one-hot, one-cycle accept pulse
insertnew_cmd  out  1  lists_manager command pulse
insert_cmd  out  1  lists_manager command pulse
suspend_cmd  out  1  lists_manager command pulse
delete_cmd  out  1  lists_manager command pulse
ins_dlylist_out  out  1  lists_manager command pulse
id_task_out  out  8  latched operand
tcb_task_out  out  32  latched operand
pri_task_out  out  6  latched operand
valuedelay_out  out  32  latched operand
busy_out  out  1  high in ISSUE and WAIT
grant_idx_out  out  3  index of the last granted requester
err_out  out  1  one-cycle pulse on an invalid opcode

Behaviour:
- Opcodes:
  - 1 INSERTNEW, 2 INSERT, 3 SUSPEND, 4 DELETE, 5 INS_DLY.
  - 0, 6 and 7 are invalid.
- Reset (areset high at a rising edge):
  - State goes to IDLE; round-robin pointer goes to 0.
  - Every output is 0, including all operands and grant_idx_out.
  - Reset during ISSUE or WAIT aborts the operation. No further pulses are issued, and the requester is not re-granted until it is sampled valid again in IDLE.
- IDLE:
  - On a rising edge with any req_valid set, select the first set bit starting at the pointer and wrapping modulo NREQ.
  - Latch that requester's op and operands, set grant_idx_out=k, and go to ISSUE.
  - The pointer becomes (k+1) mod NREQ.
  - With no request pending, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[k]=1 together with the command pulse for the latched opcode.
  - Operands are valid in this cycle and remain stable until the next grant.
  - Valid opcode: go to WAIT and load the counter with BUSY_CYCLES.
  - Invalid opcode: no command pulse; err_out=1, req_ready[k]=1; go straight to IDLE.
- WAIT:
  - The counter decrements each cycle; at 1, go to IDLE.
  - WAIT lasts exactly BUSY_CYCLES cycles.
- Latency and throughput:
  - Valid sampled at edge t gives ready and the command pulse in cycle t+1.
  - Back-to-back grant spacing is BUSY_CYCLES+2 cycles.
- Handshake:
  - A requester keeps valid and its operands constant until it sees ready.
  - Valid still high in the cycle after ready is treated as a new request.
  - Requests present in ISSUE or WAIT are ignored.
- Exclusivity: at most one command output and at most one req_ready bit are high in any cycle.
- Operand registers keep their values in IDLE; they are not cleared.

Optional Feature:
TICK_GUARD_EN
- Defined:
  - In IDLE, no grant is made at an edge where tick_in is sampled high, or at the edge immediately after it, so that lists_manager's tick-driven delay-list update never collides with a command.
  - The pointer does not advance while the guard holds.
- Undefined: tick_in is ignored and grants are unaffected.

Test Plan:
- Reset, then req_valid=001 with op=1, tcb=AAAAAAAA, pri=0F, held until ready:
  - Expected: req_ready=001 and insertnew_cmd=1 for exactly one cycle, one cycle after valid is sampled; tcb_task_out=AAAAAAAA, pri_task_out=0F.
  - busy_out high for 1+4 cycles.
- All three requesters continuously valid, op=2:
  - Expected grant order 0,1,2,0 (grant_idx_out 0,1,2,0).
  - insert_cmd pulses spaced 6 cycles apart.
- Requester 1 with op=5, id=01, delay=00000010:
  - Expected: ins_dlylist_out pulses once; id_task_out=01, valuedelay_out=00000010 held during WAIT.
- Requester 2 with op=7:
  - Expected: err_out and req_ready=100 for one cycle; no command pulse; back in IDLE the next cycle with busy_out=0.
- areset asserted in the 2nd WAIT cycle:
  - Expected: all outputs 0 at the next edge; the next grant goes to req 0 if it is valid.
- TICK_GUARD_EN defined, tick_in high in the same cycle as req_valid=001:
  - Expected: the grant is delayed until the second edge after tick_in falls, and the command pulse follows one cycle later.
  - Without the macro, the grant is immediate.
